morse_xmit: RTL and testbench
=============================

Name: morse_xmit

Overview:
Parametrised Morse transmitter, the next generation of the lab 7 letter transmitter. It covers the full A–Z alphabet and has configurable unit length, dash length and inter-letter gap. It adds a busy/done/err handshake so a host FSM can stream letters back-to-back. It sits between a character source (switches or a sequencer) and an LED/pin driver, and runs off the system clock instead of a slowed clock.

Parameters:
UNIT_CYCLES, 1, clock cycles per Morse time unit; must be >= 1
DASH_UNITS, 3, units a dash mark is held high; must be >= 2
LETTER_GAP_UNITS, 3, units of low after the last mark of a letter, before done; must be >= 1

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
xmit  in  1  start request, sampled on the rising edge of clk
letter  in  6  character code: 0..25 = A..Z; 26..35 = digits 0..9 (DIGITS_EN only); all others invalid
led  out  1  Morse output, registered; 1 = mark
busy  out  1  high while a letter is in progress
done  out  1  one-cycle pulse when a letter completes
err  out  1  one-cycle pulse when xmit is accepted with an invalid code

Behaviour:
- Reset (async, any time, including mid-letter): state=IDLE; led=0, busy=0, done=0, err=0; unit/element counters cleared. The first edge after reset release behaves as IDLE.
- Code table is a fixed ROM of (length, pattern), up to 5 elements. Elements are sent in written order, first to last.
  - A .-  B -...  C -.-.  D -..  E .  F ..-.  G --.  H ....  I ..
  - J .---  K -.-  L .-..  M --  N -.  O ---  P .--.  Q --.-  R .-.
  - S ...  T -  U ..-  V ...-  W .--  X -..-  Y -.--  Z --..
- FSM states: IDLE, MARK, SPACE, GAP.
- IDLE: led=0, busy=0. On an edge with xmit=1:
  - Valid code: latch letter, element index=0, go to MARK. From the next cycle, led=1 and busy=1.
  - Invalid code: stay in IDLE; err=1 for exactly the next cycle; busy stays 0.
- MARK: led=1 for 1 unit (dot) or DASH_UNITS units (dash), i.e. UNIT_CYCLES or DASH_UNITS*UNIT_CYCLES cycles.
  - Not the last element: go to SPACE.
  - Last element: go to GAP.
- SPACE: led=0 for 1 unit; then increment element index and go to MARK.
- GAP: led=0 for LETTER_GAP_UNITS units; then go to IDLE.
  - In the first IDLE cycle: done=1 and busy=0.
- xmit while busy is ignored; letter changes while busy are ignored (the code is latched).
- xmit sampled in the done cycle is accepted, giving back-to-back letters. led rises on the following cycle.
- Counters are sized $clog2(DASH_UNITS*UNIT_CYCLES+1) or larger. No wrap-around is permitted within a letter.
- done and err are never both high in the same cycle.
- Total busy cycles = UNIT_CYCLES * (sum of mark units + (len-1) + LETTER_GAP_UNITS).

Optional Feature:
DIGITS_EN
- Defined: codes 26..35 map to digits 0..9, each 5 elements. The pattern for digit n is:
  - n<=5: n dots then 5-n dashes.
  - n>5: n-5 dashes then 10-n dots.
  - So 0=-----, 1=.----, 5=....., 9=----.
- Undefined: codes 26..63 are invalid, raise err, and the ROM holds 26 entries with max length 4.

Test Plan:
- Default parameters, xmit with letter=4 (E) at edge 0 → led=1 in cycle 1; led=0 in cycles 2–4; busy=1 in cycles 1–4; done=1 and busy=0 in cycle 5.
- letter=0 (A) → led pattern from cycle 1: 1,0,1,1,1,0,0,0; done in cycle 9.
- UNIT_CYCLES=4, letter=19 (T) → led high for exactly 12 cycles, then low for 12; done pulses once; busy high for 24 cycles.
- letter=30 without DIGITS_EN → err=1 for exactly 1 cycle; busy and led stay 0. With DIGITS_EN, letter=26 (0) → 5 dashes: 15 high units with 4 one-unit spaces, then the gap, then done.
- Assert reset during the second element of B (letter=1) → led, busy, done and err go to 0 immediately, without waiting for a clock edge. After release, xmit E transmits a correct E.
- Issue xmit with S in the done cycle of S, and also pulse xmit mid-letter → the second S starts the cycle after done; the mid-letter xmit has no effect; exactly 2 done pulses.

Source files
------------

// File: rtl/morse_xmit.sv
// Parametrised A-Z Morse transmitter with busy/done/err handshake.
// Define DIGITS_EN to also accept codes 26..35 as the digits 0..9.
module morse_xmit #(
    parameter int UNIT_CYCLES      = 1,
    parameter int DASH_UNITS       = 3,
    parameter int LETTER_GAP_UNITS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       xmit,
    input  logic [5:0] letter,
    output logic       led,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int DASH_CYC = DASH_UNITS * UNIT_CYCLES;
    localparam int GAP_CYC  = LETTER_GAP_UNITS * UNIT_CYCLES;
    localparam int MAX_CYC  = (DASH_CYC > GAP_CYC) ? DASH_CYC : GAP_CYC;
    localparam int CW       = $clog2(MAX_CYC + 1);
`ifdef DIGITS_EN
    localparam int NUM_CODES = 36;
`else
    localparam int NUM_CODES = 26;
`endif

    typedef enum logic [1:0] {IDLE, MARK, SPACE, GAP} state_t;

    // pat is left-justified: bit 4 is the first element sent, 1 = dash.
    typedef struct packed {
        logic [2:0] len;
        logic [4:0] pat;
    } code_t;

    function automatic code_t rom(input logic [5:0] c);
        code_t r;
        r = '{3'd0, 5'b00000};
        case (c)
            6'd0:  r = '{3'd2, 5'b01000};  // A .-
            6'd1:  r = '{3'd4, 5'b10000};  // B -...
            6'd2:  r = '{3'd4, 5'b10100};  // C -.-.
            6'd3:  r = '{3'd3, 5'b10000};  // D -..
            6'd4:  r = '{3'd1, 5'b00000};  // E .
            6'd5:  r = '{3'd4, 5'b00100};  // F ..-.
            6'd6:  r = '{3'd3, 5'b11000};  // G --.
            6'd7:  r = '{3'd4, 5'b00000};  // H ....
            6'd8:  r = '{3'd2, 5'b00000};  // I ..
            6'd9:  r = '{3'd4, 5'b01110};  // J .---
            6'd10: r = '{3'd3, 5'b10100};  // K -.-
            6'd11: r = '{3'd4, 5'b01000};  // L .-..
            6'd12: r = '{3'd2, 5'b11000};  // M --
            6'd13: r = '{3'd2, 5'b10000};  // N -.
            6'd14: r = '{3'd3, 5'b11100};  // O ---
            6'd15: r = '{3'd4, 5'b01100};  // P .--.
            6'd16: r = '{3'd4, 5'b11010};  // Q --.-
            6'd17: r = '{3'd3, 5'b01000};  // R .-.
            6'd18: r = '{3'd3, 5'b00000};  // S ...
            6'd19: r = '{3'd1, 5'b10000};  // T -
            6'd20: r = '{3'd3, 5'b00100};  // U ..-
            6'd21: r = '{3'd4, 5'b00010};  // V ...-
            6'd22: r = '{3'd3, 5'b01100};  // W .--
            6'd23: r = '{3'd4, 5'b10010};  // X -..-
            6'd24: r = '{3'd4, 5'b10110};  // Y -.--
            6'd25: r = '{3'd4, 5'b11000};  // Z --..
`ifdef DIGITS_EN
            default: begin
                // Digits 0..5: n dots then dashes; 6..9: n-5 dashes then dots.
                if (c >= 6'd26 && c <= 6'd35) begin
                    r.len = 3'd5;
                    if (c <= 6'd31) r.pat = 5'b11111 >> (c - 6'd26);
                    else            r.pat = ~(5'b11111 >> (c - 6'd31));
                end
            end
`else
            default: r = '{3'd0, 5'b00000};
`endif
        endcase
        return r;
    endfunction

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [2:0]    len_q;
    logic [4:0]    pat_q;
    code_t         code;
    logic          valid;
    logic [CW-1:0] mark_last;

    always_comb begin
        code      = rom(letter);
        valid     = (letter < 6'(NUM_CODES));
        mark_last = pat_q[3'd4 - idx] ? CW'(DASH_CYC - 1) : CW'(UNIT_CYCLES - 1);
    end

    // NOTE: every register here updates with <= so all next-state terms read
    // the values from before this edge, regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            len_q <= '0;
            pat_q <= '0;
            led   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (xmit) begin
                        if (valid) begin
                            len_q <= code.len;
                            pat_q <= code.pat;
                            idx   <= '0;
                            led   <= 1'b1;
                            busy  <= 1'b1;
                            state <= MARK;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                MARK: begin
                    if (cnt == mark_last) begin
                        cnt   <= '0;
                        led   <= 1'b0;
                        state <= (idx == len_q - 3'd1) ? GAP : SPACE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                SPACE: begin
                    if (cnt == CW'(UNIT_CYCLES - 1)) begin
                        cnt   <= '0;
                        idx   <= idx + 3'd1;
                        led   <= 1'b1;
                        state <= MARK;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                GAP: begin
                    if (cnt == CW'(GAP_CYC - 1)) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_morse_xmit.sv
// Directed bench for morse_xmit: table of letters at default timing plus
// reset, invalid-code, long-unit and back-to-back sequences.
module tb_morse_xmit;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       xmit = 1'b0;
    logic [5:0] letter = '0;
    logic       led, busy, done, err;
    logic       xmit4 = 1'b0;
    logic [5:0] letter4 = '0;
    logic       led4, busy4, done4, err4;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string      name;
        logic [5:0] code;
        string      led;   // expected led per cycle from cycle 1; length = busy cycles
    } vec_t;

    vec_t vecs[8];

    morse_xmit dut (
        .clk(clk), .reset(reset), .xmit(xmit), .letter(letter),
        .led(led), .busy(busy), .done(done), .err(err)
    );

    morse_xmit #(.UNIT_CYCLES(4)) dut4 (
        .clk(clk), .reset(reset), .xmit(xmit4), .letter(letter4),
        .led(led4), .busy(busy4), .done(done4), .err(err4)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send_check(input string name, input logic [5:0] code, input string exp_led);
        int b;
        b = exp_led.len();
        @(negedge clk);
        xmit = 1'b1;
        letter = code;
        @(negedge clk);
        xmit = 1'b0;
        letter = 6'd63;
        for (int k = 1; k <= b; k++) begin
            if (k > 1) @(negedge clk);
            check($sformatf("%s led c%0d", name, k), 32'(led), 32'(exp_led[k-1] == "1"));
            check($sformatf("%s busy c%0d", name, k), 32'(busy), 32'd1);
            check($sformatf("%s done c%0d", name, k), 32'(done), 32'd0);
            check($sformatf("%s err c%0d", name, k), 32'(err), 32'd0);
        end
        @(negedge clk);
        check($sformatf("%s done_pulse", name), 32'(done), 32'd1);
        check($sformatf("%s busy_end", name), 32'(busy), 32'd0);
        check($sformatf("%s led_end", name), 32'(led), 32'd0);
        @(negedge clk);
        check($sformatf("%s done_clear", name), 32'(done), 32'd0);
    endtask

    task automatic check_invalid(input string name, input logic [5:0] code);
        @(negedge clk);
        xmit = 1'b1;
        letter = code;
        @(negedge clk);
        xmit = 1'b0;
        check($sformatf("%s err", name), 32'(err), 32'd1);
        check($sformatf("%s busy", name), 32'(busy), 32'd0);
        check($sformatf("%s led", name), 32'(led), 32'd0);
        check($sformatf("%s done", name), 32'(done), 32'd0);
        @(negedge clk);
        check($sformatf("%s err_clear", name), 32'(err), 32'd0);
        check($sformatf("%s busy_after", name), 32'(busy), 32'd0);
        check($sformatf("%s led_after", name), 32'(led), 32'd0);
    endtask

    initial begin
        int dones;
        int highs;
        string b2b_led, b2b_busy, b2b_done;

        vecs[0] = '{"E", 6'd4,  "1000"};
        vecs[1] = '{"A", 6'd0,  "10111000"};
        vecs[2] = '{"T", 6'd19, "111000"};
        vecs[3] = '{"S", 6'd18, "10101000"};
        vecs[4] = '{"M", 6'd12, "1110111000"};
        vecs[5] = '{"K", 6'd10, "111010111000"};
        vecs[6] = '{"Q", 6'd16, "1110111010111000"};
        vecs[7] = '{"Z", 6'd25, "11101110101000"};

        #2 reset = 1'b1;
        #1;
        check("reset led", 32'(led), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset err", 32'(err), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) send_check(vecs[i].name, vecs[i].code, vecs[i].led);

        check_invalid("code63", 6'd63);
`ifdef DIGITS_EN
        send_check("digit0", 6'd26, {"1110111011101110111", "000"});
        send_check("digit9", 6'd35, {"11101110111011101", "000"});
`else
        check_invalid("code30", 6'd30);
        check_invalid("code26", 6'd26);
`endif

        // UNIT_CYCLES=4, T: 12 cycles high, 12 low, done at cycle 25.
        @(negedge clk);
        xmit4 = 1'b1;
        letter4 = 6'd19;
        @(negedge clk);
        xmit4 = 1'b0;
        dones = 0;
        highs = 0;
        for (int k = 1; k <= 30; k++) begin
            if (k > 1) @(negedge clk);
            if (led4) highs++;
            if (done4) dones++;
            check($sformatf("u4 led c%0d", k), 32'(led4), 32'(k <= 12));
            check($sformatf("u4 busy c%0d", k), 32'(busy4), 32'(k <= 24));
            check($sformatf("u4 done c%0d", k), 32'(done4), 32'(k == 25));
        end
        check("u4 high_cycles", 32'(highs), 32'd12);
        check("u4 done_count", 32'(dones), 32'd1);

        // Reset during the second element (a dot) of B.
        @(negedge clk);
        xmit = 1'b1;
        letter = 6'd1;
        @(negedge clk);
        xmit = 1'b0;
        repeat (4) @(negedge clk);
        check("B elem2 led", 32'(led), 32'd1);
        check("B elem2 busy", 32'(busy), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("async led", 32'(led), 32'd0);
        check("async busy", 32'(busy), 32'd0);
        check("async done", 32'(done), 32'd0);
        check("async err", 32'(err), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        send_check("E_after_reset", 6'd4, "1000");

        // Back-to-back S with a mid-letter xmit carrying a different code.
        b2b_led  = "101010000101010000";
        b2b_busy = "111111110111111110";
        b2b_done = "000000001000000001";
        dones = 0;
        @(negedge clk);
        xmit = 1'b1;
        letter = 6'd18;
        @(negedge clk);
        xmit = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) @(negedge clk);
            if (done) dones++;
            if (k <= 18) begin
                check($sformatf("b2b led c%0d", k), 32'(led), 32'(b2b_led[k-1] == "1"));
                check($sformatf("b2b busy c%0d", k), 32'(busy), 32'(b2b_busy[k-1] == "1"));
                check($sformatf("b2b done c%0d", k), 32'(done), 32'(b2b_done[k-1] == "1"));
            end
            xmit = 1'b0;
            letter = 6'd18;
            if (k == 3) begin
                xmit = 1'b1;
                letter = 6'd19;
            end
            if (k == 9) xmit = 1'b1;
        end
        check("b2b done_count", 32'(dones), 32'd2);
        check("b2b err", 32'(err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
